// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode constants, slot state type and opcode legality check
//
// Purpose: constants and helpers shared by the ALU share arbiter and its
// round-robin sub-block.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_OP_W  = 4;

  localparam logic [ALU_OP_W-1:0] ALUOP_AND = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALUOP_OR  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALUOP_ADD = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALUOP_SUB = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALUOP_SLT = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALUOP_NOR = 4'd12;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic is_legal_aluop(input logic [ALU_OP_W-1:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      ALUOP_AND, ALUOP_OR, ALUOP_ADD,
      ALUOP_SUB, ALUOP_SLT, ALUOP_NOR: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a registered priority pointer
//
// Purpose: picks one of two requesters when enabled; the pointer side wins
// when both request, and the pointer only moves on such a contended grant.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en_i           a grant may be issued this cycle
//   req_i[1:0]     request lines, bit N = requester N
//   gnt_valid_o    a grant is issued this cycle
//   gnt_id_o       granted requester (meaningful when gnt_valid_o)
//   ptr_o          current priority pointer (0 = requester 0 preferred)
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o,
  output logic       ptr_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_valid_o = en_i & (|req_i);
    // With a single request the id is simply which line is up.
    gnt_id_o    = (&req_i) ? ptr_q : req_i[1];
    ptr_d       = ptr_q;
    // Granted side equals ptr_q, so flipping hands priority to the loser.
    if (en_i && (&req_i)) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between two requesters
//
// Purpose: round-robin arbitration of two valid/ready request ports onto a
// single external ALU, with the result captured in a one-entry output slot
// tagged with the winning requester id.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   reqN_valid_i/ready_o      request handshake, requester N (N = 0, 1)
//   reqN_a_i/b_i/op_i         operands and aluop, requester N
//   alu_a_o/b_o/op_o          to the shared ALU
//   alu_res_i/zero_i          from the shared ALU (combinational)
//   rsp_valid_o/ready_i       result slot handshake
//   rsp_id_o/res_o/zero_o     captured requester id, result, zero flag
//   rsp_err_o                 captured op was outside the legal set
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [OP_W-1:0]  req0_op_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [OP_W-1:0]  req1_op_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [OP_W-1:0]  alu_op_o,
  input  logic [WIDTH-1:0] alu_res_i,
  input  logic             alu_zero_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_res_o,
  output logic             rsp_zero_o,
  output logic             rsp_err_o
);

  slot_state_e      state_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_res_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;

  logic can_accept;
  logic gnt_valid;
  logic gnt_id;
  logic rr_ptr;
  logic sel;

  // The slot may drain and refill in the same cycle.
  assign can_accept = (state_q == SLOT_EMPTY) || rsp_ready_i;

  rr_arb2 u_rr_arb2 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (can_accept),
    .req_i       ({req1_valid_i, req0_valid_i}),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id),
    .ptr_o       (rr_ptr)
  );

  assign req0_ready_o = gnt_valid & ~gnt_id;
  assign req1_ready_o = gnt_valid &  gnt_id;

  // Idle cycles still drive a real requester so the ALU never sees X.
  assign sel      = gnt_valid ? gnt_id : rr_ptr;
  assign alu_a_o  = sel ? req1_a_i  : req0_a_i;
  assign alu_b_o  = sel ? req1_b_i  : req0_b_i;
  assign alu_op_o = sel ? req1_op_i : req0_op_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SLOT_EMPTY;
      rsp_id_q   <= 1'b0;
      rsp_res_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      // gnt_valid already implies can_accept, so it is the accept strobe.
      if (gnt_valid) begin
        state_q    <= SLOT_FULL;
        rsp_id_q   <= gnt_id;
        rsp_res_q  <= alu_res_i;
        rsp_zero_q <= alu_zero_i;
        rsp_err_q  <= ~is_legal_aluop(alu_op_o);
      end else begin
        case (state_q)
          SLOT_EMPTY: state_q <= SLOT_EMPTY;
          SLOT_FULL:  if (rsp_ready_i) state_q <= SLOT_EMPTY;
          default:    state_q <= SLOT_EMPTY;
        endcase
      end
    end
  end

  assign rsp_valid_o = (state_q == SLOT_FULL);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_res_o   = rsp_res_q;
  assign rsp_zero_o  = rsp_zero_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for the ALU share arbiter
module tb_alu_share_arbiter;

  localparam int W  = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v0, v1, rdy0, rdy1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic [OW-1:0] op0, op1;
  logic [W-1:0]  alu_a, alu_b, alu_res;
  logic [OW-1:0] alu_op;
  logic          alu_zero;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0]  rsp_res;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .OP_W(OW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req0_valid_i (v0),
    .req0_ready_o (rdy0),
    .req0_a_i     (a0),
    .req0_b_i     (b0),
    .req0_op_i    (op0),
    .req1_valid_i (v1),
    .req1_ready_o (rdy1),
    .req1_a_i     (a1),
    .req1_b_i     (b1),
    .req1_op_i    (op1),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_res_i    (alu_res),
    .alu_zero_i   (alu_zero),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_res_o    (rsp_res),
    .rsp_zero_o   (rsp_zero),
    .rsp_err_o    (rsp_err)
  );

  // Behavioural MIPS ALU standing in for the real one; undefined ops give a^b.
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [OW-1:0] op);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic legal(input logic [OW-1:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
  endfunction

  assign alu_res  = alu_fn(alu_a, alu_b, alu_op);
  assign alu_zero = (alu_res == '0);

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic m_full, m_ptr, hs0, hs1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one-deep slot, round-robin preference that swaps after contention.
  always @(negedge clk) begin
    logic can, g0, g1, sel;
    if (!rst_n) begin
      m_full = 1'b0;
      m_ptr  = 1'b0;
      hs0    = 1'b0;
      hs1    = 1'b0;
      sb.delete();
    end else begin
      can = !m_full || rsp_ready;
      g0  = 1'b0;
      g1  = 1'b0;
      if (can) begin
        if (v0 && v1) begin
          g0 = !m_ptr;
          g1 = m_ptr;
        end else begin
          g0 = v0;
          g1 = v1;
        end
      end
      chk("rsp_valid", W'(rsp_valid), W'(m_full));
      chk("req0_ready", W'(rdy0), W'(g0));
      chk("req1_ready", W'(rdy1), W'(g1));
      sel = (g0 || g1) ? g1 : m_ptr;
      chk("alu_a", alu_a, sel ? a1 : a0);
      chk("alu_op", W'(alu_op), W'(sel ? op1 : op0));
      if (g0 || g1) begin
        rsp_t e;
        e.id   = g1;
        e.res  = g1 ? alu_fn(a1, b1, op1) : alu_fn(a0, b0, op0);
        e.zero = (e.res == '0);
        e.err  = g1 ? !legal(op1) : !legal(op0);
        sb.push_back(e);
      end
      if (can && v0 && v1) m_ptr = g0;
      m_full = g0 || g1 || (m_full && !rsp_ready);
      hs0 = g0;
      hs1 = g1;
    end
  end

  // Monitor: compares the presented result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got rsp_valid=1 expected no pending result at %0t", $time);
      end else begin
        chk("rsp_id", W'(rsp_id), W'(sb[0].id));
        chk("rsp_res", rsp_res, sb[0].res);
        chk("rsp_zero", W'(rsp_zero), W'(sb[0].zero));
        chk("rsp_err", W'(rsp_err), W'(sb[0].err));
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic port, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [OW-1:0] op);
    bit done;
    done = 1'b0;
    if (port) begin v1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    else      begin v0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (port ? hs1 : hs0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got no handshake expected one within 20 cycles");
    end
    tick();
    if (port) v1 = 1'b0; else v0 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    v0 = 1'b0; a0 = '0; b0 = '0; op0 = '0;
    v1 = 1'b0; a1 = '0; b1 = '0; op1 = '0;
    #1;
    chk("reset_valid", W'(rsp_valid), '0);
    chk("reset_id", W'(rsp_id), '0);
    chk("reset_res", rsp_res, '0);
    chk("reset_zero", W'(rsp_zero), '0);
    chk("reset_err", W'(rsp_err), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Directed single-requester operations.
    issue(1'b0, 32'd6, 32'd3, 4'd2);
    issue(1'b1, 32'd3, 32'd3, 4'd6);
    issue(1'b1, 32'd3, 32'd7, 4'd7);
    issue(1'b1, 32'd6, 32'd3, 4'd12);
    issue(1'b0, 32'd5, 32'd9, 4'd3);
    tick();

    // Continuous contention: AND from 0, OR from 1.
    a0 = 32'd6; b0 = 32'd3; op0 = 4'd0;
    a1 = 32'd6; b1 = 32'd3; op1 = 4'd1;
    v0 = 1'b1; v1 = 1'b1;
    repeat (8) tick();

    // Backpressure with the slot full, then release.
    rsp_ready = 1'b0;
    repeat (6) tick();
    rsp_ready = 1'b1;
    repeat (4) tick();
    v0 = 1'b0; v1 = 1'b0;
    tick();

    // Asynchronous reset while full, then contention must start with req0.
    rsp_ready = 1'b0;
    v0 = 1'b1; a0 = 32'd11; b0 = 32'd4; op0 = 4'd2;
    tick();
    v0 = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset_valid", W'(rsp_valid), '0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    a0 = 32'd6; b0 = 32'd3; op0 = 4'd0;
    a1 = 32'd6; b1 = 32'd3; op1 = 4'd1;
    v0 = 1'b1; v1 = 1'b1;
    repeat (4) tick();
    v0 = 1'b0; v1 = 1'b0;
    tick();

    // Randomized traffic with withdrawals, illegal ops and backpressure.
    for (int c = 0; c < 500; c++) begin
      if (!v0 || hs0) begin
        v0  = ($urandom_range(0, 3) != 0);
        a0  = $urandom;
        b0  = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
        op0 = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        v0 = 1'b0;
      end
      if (!v1 || hs1) begin
        v1  = ($urandom_range(0, 3) != 0);
        a1  = $urandom;
        b1  = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
        op1 = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        v1 = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
    repeat (4) tick();
    chk("sb_drained", W'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
